// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - redirect inputs and fetch outputs of the PC sequencer
interface pc_fetch_if #(
    parameter int WL    = 32,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             br_taken;
    logic [15:0]      br_off;
    logic             jmp;
    logic [25:0]      jmp_tgt;
    logic             jr;
    logic [WL-1:0]    jr_tgt;
    logic [WL-1:0]    ima;
    logic [WL-1:0]    pcp1;
    logic             fvld;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] fcnt;

    modport master (
        output stall, br_taken, br_off, jmp, jmp_tgt, jr, jr_tgt,
        input  ima, pcp1, fvld, halted, err, fcnt
    );

    modport slave (
        input  stall, br_taken, br_off, jmp, jmp_tgt, jr, jr_tgt,
        output ima, pcp1, fvld, halted, err, fcnt
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - word-addressed PC register, next-PC select and RUN/HALT fetch sequencer
module pc_fetch_unit #(
    parameter int WL        = 32,
    parameter int LAST_ADDR = 12,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    pc_fetch_if.slave   fif
);
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    localparam logic [WL-1:0]    LAST    = WL'(LAST_ADDR);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [WL-1:0]    pc_q, pc_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;

    logic [WL-1:0]    pcp1;
    logic [WL-1:0]    br_tgt;
    logic [WL-1:0]    j_tgt;
    logic [WL-1:0]    target;
    logic             redirect;
    logic             retire;

    assign pcp1   = pc_q + WL'(1);
    assign br_tgt = pcp1 + {{(WL-16){fif.br_off[15]}}, fif.br_off};
    assign j_tgt  = {pcp1[WL-1:26], fif.jmp_tgt};

    // Redirect priority JR > JMP > branch; sequential only when none asserted
    always_comb begin
        target   = br_tgt;
        redirect = 1'b0;
        if (fif.jr) begin
            target   = fif.jr_tgt;
            redirect = 1'b1;
        end else if (fif.jmp) begin
            target   = j_tgt;
            redirect = 1'b1;
        end else if (fif.br_taken) begin
            target   = br_tgt;
            redirect = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        retire  = 1'b0;
        if (state_q == RUN && !fif.stall) begin
            // The fetch in flight always retires, even when it leads to HALT
            retire = 1'b1;
            if (redirect) begin
                if (target <= LAST) begin
                    pc_d = target;
                end else begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end
            end else if (pc_q < LAST) begin
                pc_d = pcp1;
            end else begin
                state_d = HALT;
            end
        end
        fcnt_d = (retire && fcnt_q != CNT_MAX) ? fcnt_q + CNT_W'(1) : fcnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= '0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign fif.ima    = pc_q;
    assign fif.pcp1   = pcp1;
    assign fif.fvld   = (state_q == RUN);
    assign fif.halted = (state_q == HALT);
    assign fif.err    = err_q;
    assign fif.fcnt   = fcnt_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit (default and 4-bit counter instances)
module tb_pc_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_fetch_if #(.WL(32), .CNT_W(16)) if_a ();
    pc_fetch_if #(.WL(32), .CNT_W(4))  if_b ();

    pc_fetch_unit #(.WL(32), .LAST_ADDR(12), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .fif(if_a));
    pc_fetch_unit #(.WL(32), .LAST_ADDR(12), .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .fif(if_b));

    typedef struct {
        bit          dut;
        string       name;
        logic [31:0] ima;
        logic [31:0] pcp1;
        logic        fvld;
        logic        halted;
        logic        err;
        logic [15:0] fcnt;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic cmp(string nm, string fld, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.dut == 1'b0) begin
                    cmp(e.name, "ima",    if_a.ima,          e.ima);
                    cmp(e.name, "pcp1",   if_a.pcp1,         e.pcp1);
                    cmp(e.name, "fvld",   32'(if_a.fvld),    32'(e.fvld));
                    cmp(e.name, "halted", 32'(if_a.halted),  32'(e.halted));
                    cmp(e.name, "err",    32'(if_a.err),     32'(e.err));
                    cmp(e.name, "fcnt",   32'(if_a.fcnt),    32'(e.fcnt));
                end else begin
                    cmp(e.name, "ima",    if_b.ima,          e.ima);
                    cmp(e.name, "fvld",   32'(if_b.fvld),    32'(e.fvld));
                    cmp(e.name, "halted", 32'(if_b.halted),  32'(e.halted));
                    cmp(e.name, "fcnt",   32'(if_b.fcnt),    32'(e.fcnt));
                end
            end
        end
    end

    task automatic push(bit d, string nm, logic [31:0] ima, logic fv, logic ht, logic er, logic [15:0] fc);
        exp_t e;
        e.dut = d; e.name = nm; e.ima = ima; e.pcp1 = ima + 32'd1;
        e.fvld = fv; e.halted = ht; e.err = er; e.fcnt = fc;
        sb.push_back(e);
    endtask

    task automatic step(bit d, string nm, logic [31:0] ima, logic fv, logic ht, logic er, logic [15:0] fc);
        @(posedge clk);
        #1;
        push(d, nm, ima, fv, ht, er, fc);
    endtask

    task automatic clr_inputs();
        if_a.stall = 0; if_a.br_taken = 0; if_a.br_off = 0; if_a.jmp = 0;
        if_a.jmp_tgt = 0; if_a.jr = 0; if_a.jr_tgt = 0;
        if_b.stall = 0; if_b.br_taken = 0; if_b.br_off = 0; if_b.jmp = 0;
        if_b.jmp_tgt = 0; if_b.jr = 0; if_b.jr_tgt = 0;
    endtask

    task automatic do_reset(string nm);
        @(negedge clk);
        rst_n = 1'b0;
        clr_inputs();
        #1;
        push(1'b0, nm, 32'd0, 1'b1, 1'b0, 1'b0, 16'd0);
        ->chk_ev;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clr_inputs();
        do_reset("reset");

        // free-run to the last address, then halt
        for (int k = 1; k <= 12; k++) step(1'b0, "seq", 32'(k), 1'b1, 1'b0, 1'b0, 16'(k));
        step(1'b0, "seq_end", 32'd12, 1'b0, 1'b1, 1'b0, 16'd13);
        step(1'b0, "halt_hold", 32'd12, 1'b0, 1'b1, 1'b0, 16'd13);

        // backward then forward branch
        do_reset("reset2");
        for (int k = 1; k <= 4; k++) step(1'b0, "to4", 32'(k), 1'b1, 1'b0, 1'b0, 16'(k));
        if_a.br_taken = 1; if_a.br_off = 16'hFFFD;
        step(1'b0, "br_back", 32'd2, 1'b1, 1'b0, 1'b0, 16'd5);
        if_a.br_taken = 0;
        step(1'b0, "seq3", 32'd3, 1'b1, 1'b0, 1'b0, 16'd6);
        step(1'b0, "seq4", 32'd4, 1'b1, 1'b0, 1'b0, 16'd7);
        if_a.br_taken = 1; if_a.br_off = 16'd3;
        step(1'b0, "br_fwd", 32'd8, 1'b1, 1'b0, 1'b0, 16'd8);
        if_a.br_taken = 0;

        // priority JR > JMP > BR, then JMP alone, then stall holding a jump
        do_reset("reset3");
        for (int k = 1; k <= 3; k++) step(1'b0, "to3", 32'(k), 1'b1, 1'b0, 1'b0, 16'(k));
        if_a.jr = 1; if_a.jr_tgt = 32'd10; if_a.jmp = 1; if_a.jmp_tgt = 26'd1;
        if_a.br_taken = 1; if_a.br_off = 16'd0;
        step(1'b0, "jr_wins", 32'd10, 1'b1, 1'b0, 1'b0, 16'd4);
        if_a.jr = 0; if_a.br_taken = 0;
        step(1'b0, "jmp", 32'd1, 1'b1, 1'b0, 1'b0, 16'd5);
        if_a.jmp = 0;
        for (int k = 2; k <= 6; k++) step(1'b0, "to6", 32'(k), 1'b1, 1'b0, 1'b0, 16'(4 + k));
        if_a.stall = 1; if_a.jmp = 1; if_a.jmp_tgt = 26'd0;
        for (int k = 0; k < 3; k++) step(1'b0, "stall", 32'd6, 1'b1, 1'b0, 1'b0, 16'd10);
        if_a.stall = 0;
        step(1'b0, "unstall_jmp", 32'd0, 1'b1, 1'b0, 1'b0, 16'd11);
        if_a.jmp = 0;

        // out-of-range JR halts with ERR, inputs then ignored, async reset clears
        step(1'b0, "seq1", 32'd1, 1'b1, 1'b0, 1'b0, 16'd12);
        step(1'b0, "seq2", 32'd2, 1'b1, 1'b0, 1'b0, 16'd13);
        if_a.jr = 1; if_a.jr_tgt = 32'd20;
        step(1'b0, "jr_oor", 32'd2, 1'b0, 1'b1, 1'b1, 16'd14);
        if_a.jr_tgt = 32'd5; if_a.jmp = 1; if_a.br_taken = 1;
        for (int k = 0; k < 2; k++) step(1'b0, "err_hold", 32'd2, 1'b0, 1'b1, 1'b1, 16'd14);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push(1'b0, "async_rst", 32'd0, 1'b1, 1'b0, 1'b0, 16'd0);
        ->chk_ev;
        clr_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // boundary: target == LAST_ADDR accepted, LAST_ADDR+1 and wrapped targets rejected
        if_a.br_taken = 1; if_a.br_off = 16'd11;
        step(1'b0, "br_last", 32'd12, 1'b1, 1'b0, 1'b0, 16'd1);
        if_a.br_taken = 0; if_a.jmp = 1; if_a.jmp_tgt = 26'd13;
        step(1'b0, "jmp_oor", 32'd12, 1'b0, 1'b1, 1'b1, 16'd2);
        do_reset("reset4");
        if_a.br_taken = 1; if_a.br_off = 16'hFFFE;
        step(1'b0, "br_wrap", 32'd0, 1'b0, 1'b1, 1'b1, 16'd1);

        // 4-bit counter saturates on a branch self-loop
        do_reset("reset5");
        for (int k = 1; k <= 5; k++) step(1'b1, "b_to5", 32'(k), 1'b1, 1'b0, 1'b0, 16'(k));
        if_b.br_taken = 1; if_b.br_off = 16'hFFFF;
        for (int k = 1; k <= 20; k++)
            step(1'b1, "b_sat", 32'd5, 1'b1, 1'b0, 1'b0, (5 + k > 15) ? 16'd15 : 16'(5 + k));

        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
